// File: rtl/stream_arb_pkg.sv
// stream_arb_pkg: shared arbitration state type and round-robin helper for stream_arbiter.
package stream_arb_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    // Successor of a requester index, wrapping to zero past the last requester.
    function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned num_req);
        int unsigned nxt_v;
        if (ptr + 32'd1 >= num_req) begin
            nxt_v = 32'd0;
        end else begin
            nxt_v = ptr + 32'd1;
        end
        return nxt_v;
    endfunction

endpackage

// File: rtl/stream_arbiter_chk.sv
// stream_arbiter_chk: protocol checks on the arbiter outputs (stall stability, single ready).
module stream_arbiter_chk #(
    parameter int  NUM_REQ  = 4,
    parameter type TYPE     = logic,
    localparam int ID_WIDTH = $clog2(NUM_REQ)
) (
    input logic                clk,
    input logic                rstn,
    input logic [NUM_REQ-1:0]  req_ready,
    input logic                out_valid,
    input logic                out_ready,
    input TYPE                 out_data,
    input logic                out_last,
    input logic [ID_WIDTH-1:0] out_id
);

    a_hold_stable: assert property (@(posedge clk) disable iff (!rstn)
        (out_valid && !out_ready) |=> (out_valid && $stable(out_data) && $stable(out_last) && $stable(out_id)))
        else $error("stream_arbiter: output beat changed while stalled");

    a_ready_onehot: assert property (@(posedge clk) disable iff (!rstn) $onehot0(req_ready))
        else $error("stream_arbiter: more than one req_ready asserted");

endmodule

// File: rtl/stream_arbiter_rr_pick.sv
// rr_pick: rotate-priority encoder; returns the first asserted request at or after ptr, with wrap.
module rr_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         found,
    output logic [W-1:0] idx
);

    // Walk the request vector starting at ptr; the first hit latches into idx.
    always_comb begin
        int unsigned j_s;
        logic        hit_s;
        found = 1'b0;
        idx   = '0;
        j_s   = 32'd0;
        hit_s = 1'b0;
        for (int k = 0; k < N; k++) begin
            j_s   = (32'(ptr) + 32'(k)) % 32'(N);
            hit_s = !found && req[W'(j_s)];
            idx   = hit_s ? W'(j_s) : idx;
            found = found | hit_s;
        end
    end

endmodule

// File: rtl/stream_arbiter.sv
// stream_arbiter: round-robin merge of NUM_REQ valid/ready streams into one registered, id-tagged output.
// Define STREAM_ARB_LOCK_EN to keep the grant on one requester until its req_last beat.
module stream_arbiter
    import stream_arb_pkg::*;
#(
    parameter int  NUM_REQ    = 4,
    parameter int  DATA_WIDTH = 1,
    parameter type TYPE       = logic [DATA_WIDTH-1:0],
    localparam int ID_WIDTH   = $clog2(NUM_REQ)
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [NUM_REQ-1:0]  req_valid,
    output logic [NUM_REQ-1:0]  req_ready,
    input  TYPE                 req_data [NUM_REQ],
    input  logic [NUM_REQ-1:0]  req_last,
    output logic                out_valid,
    input  logic                out_ready,
    output TYPE                 out_data,
    output logic                out_last,
    output logic [ID_WIDTH-1:0] out_id
);

    if (NUM_REQ < 2) begin : g_num_req_chk
        $fatal(1, "stream_arbiter: NUM_REQ must be >= 2");
    end

    logic [ID_WIDTH-1:0] ptr_r;
    logic [ID_WIDTH-1:0] ptr_nxt_s;
    logic [ID_WIDTH-1:0] pick_idx_s;
    logic [ID_WIDTH-1:0] grant_s;
    logic                pick_found_s;
    logic                grant_valid_s;
    logic                slot_free_s;
    logic                accept_s;

    rr_pick #(.N(NUM_REQ), .W(ID_WIDTH)) u_pick (
        .req   (req_valid),
        .ptr   (ptr_r),
        .found (pick_found_s),
        .idx   (pick_idx_s)
    );

    assign slot_free_s = !out_valid || out_ready;
    assign accept_s    = slot_free_s && grant_valid_s && req_valid[grant_s];

`ifdef STREAM_ARB_LOCK_EN
    arb_state_e          state_r;
    arb_state_e          state_nxt_s;
    logic [ID_WIDTH-1:0] lock_id_r;
    logic [ID_WIDTH-1:0] lock_id_nxt_s;

    // While locked the owner keeps the grant even with valid low, so everyone else stalls.
    always_comb begin
        grant_valid_s = pick_found_s;
        grant_s       = pick_idx_s;
        if (state_r == ARB_LOCKED) begin
            grant_valid_s = 1'b1;
            grant_s       = lock_id_r;
        end else begin
            grant_valid_s = pick_found_s;
            grant_s       = pick_idx_s;
        end
    end

    // Packet-lock next state; the pointer only moves when a packet completes.
    always_comb begin
        state_nxt_s   = state_r;
        lock_id_nxt_s = lock_id_r;
        ptr_nxt_s     = ptr_r;
        case (state_r)
            ARB_IDLE: begin
                if (accept_s && !req_last[grant_s]) begin
                    state_nxt_s   = ARB_LOCKED;
                    lock_id_nxt_s = grant_s;
                end else if (accept_s) begin
                    ptr_nxt_s = ID_WIDTH'(rr_next(32'(grant_s), NUM_REQ));
                end else begin
                    state_nxt_s = ARB_IDLE;
                end
            end
            ARB_LOCKED: begin
                if (accept_s && req_last[grant_s]) begin
                    state_nxt_s = ARB_IDLE;
                    ptr_nxt_s   = ID_WIDTH'(rr_next(32'(lock_id_r), NUM_REQ));
                end else begin
                    state_nxt_s = ARB_LOCKED;
                end
            end
            default: begin
                state_nxt_s = ARB_IDLE;
            end
        endcase
    end

    // Lock state and owner registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r   <= ARB_IDLE;
            lock_id_r <= '0;
        end else begin
            state_r   <= state_nxt_s;
            lock_id_r <= lock_id_nxt_s;
        end
    end
`else
    assign grant_valid_s = pick_found_s;
    assign grant_s       = pick_idx_s;
    assign ptr_nxt_s     = accept_s ? ID_WIDTH'(rr_next(32'(grant_s), NUM_REQ)) : ptr_r;
`endif

    // Ready goes only to the granted requester, and only when its beat is actually taken.
    always_comb begin
        req_ready = '0;
        for (int g = 0; g < NUM_REQ; g++) begin
            req_ready[g] = accept_s && (grant_s == ID_WIDTH'(g));
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr_r <= '0;
        end else begin
            ptr_r <= ptr_nxt_s;
        end
    end

    // Output slice control: a drain and a new accept in the same cycle keep valid high.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_id    <= '0;
        end else if (accept_s) begin
            out_valid <= 1'b1;
            out_last  <= req_last[grant_s];
            out_id    <= grant_s;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= out_valid;
        end
    end

    // Payload register; contents are meaningless until out_valid, so no reset.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            out_data <= req_data[grant_s];
        end
    end

    stream_arbiter_chk #(.NUM_REQ(NUM_REQ), .TYPE(TYPE)) u_chk (
        .clk       (clk),
        .rstn      (rstn),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_id    (out_id)
    );

endmodule

// File: tb/tb_stream_arbiter.sv
// tb_stream_arbiter: vector tables, packet sequences and random traffic against a scan-order model.
module tb_stream_arbiter;

    localparam int N   = 4;
    localparam int DW  = 8;
    localparam int IDW = $clog2(N);
    typedef logic [DW-1:0] data_t;

    logic           clk = 1'b0;
    logic           rstn;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    data_t          req_data [N];
    logic [N-1:0]   req_last;
    logic           out_valid;
    logic           out_ready;
    data_t          out_data;
    logic           out_last;
    logic [IDW-1:0] out_id;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int    m_ptr, m_owner, m_id, m_g;
    bit    m_locked, m_valid, m_last, m_acc;
    data_t m_data;
    logic [N-1:0] m_rdy;

    int got_ids[$];

    stream_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .req_last  (req_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_id    (out_id)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0; m_owner = 0; m_id = 0; m_g = 0;
        m_locked = 1'b0; m_valid = 1'b0; m_last = 1'b0; m_acc = 1'b0;
        m_rdy = '0;
    endtask

    // Grant: the owner of an open packet, else the first valid requester in rotation order from ptr.
    task automatic model_grant();
        int order[$];
        bit have;
        have = 1'b0;
        m_g = 0;
        if (m_locked) begin
            have = 1'b1;
            m_g  = m_owner;
        end else begin
            for (int k = 0; k < N; k++) order.push_back((m_ptr + k) % N);
            foreach (order[i]) begin
                if (!have && req_valid[order[i]]) begin
                    have = 1'b1;
                    m_g  = order[i];
                end
            end
        end
        m_acc = have && (!m_valid || out_ready) && req_valid[m_g];
        m_rdy = m_acc ? (4'b0001 << m_g) : 4'b0000;
    endtask

    task automatic model_update();
        if (m_acc) begin
            m_valid = 1'b1;
            m_data  = req_data[m_g];
            m_last  = req_last[m_g];
            m_id    = m_g;
`ifdef STREAM_ARB_LOCK_EN
            if (req_last[m_g]) begin
                m_locked = 1'b0;
                m_ptr    = (m_g + 1) % N;
            end else begin
                m_locked = 1'b1;
                m_owner  = m_g;
            end
`else
            m_ptr = (m_g + 1) % N;
`endif
        end else if (out_ready) begin
            m_valid = 1'b0;
        end
    endtask

    // Entered at posedge+1 with inputs already driven; returns at the next posedge+1.
    task automatic cycle();
        #2;
        model_grant();
        check("model_req_ready", 32'(req_ready), 32'(m_rdy));
        @(posedge clk);
        model_update();
        #1;
        check("model_out_valid", 32'(out_valid), 32'(m_valid));
        if (m_valid) begin
            check("model_out_data", 32'(out_data), 32'(m_data));
            check("model_out_last", 32'(out_last), 32'(m_last));
            check("model_out_id", 32'(out_id), 32'(m_id));
        end
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        req_valid = '0;
        req_last  = '0;
        out_ready = 1'b1;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_out_id", 32'(out_id), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    // Single-beat beat from requester 0 so the pointer sits at 1.
    task automatic prep_ptr1();
        req_valid = 4'b0001;
        req_last  = 4'b1111;
        req_data[0] = 8'h0A;
        cycle();
    endtask

    // Requester 1 sends a 3-beat packet (optionally pausing after beat 0); requester 0 always valid.
    task automatic pkt_seq(input int ncyc, input int gap_len, input bit gap_r0_exp);
        int b1;
        int gap_cnt;
        bit in_gap;
        bit b1_acc;
        b1 = 0;
        gap_cnt = 0;
        got_ids.delete();
        for (int c = 0; c < ncyc; c++) begin
            in_gap = (b1 == 1) && (gap_cnt < gap_len);
            if (in_gap) gap_cnt++;
            req_valid    = 4'b0001;
            req_valid[1] = (b1 < 3) && !in_gap;
            req_last     = 4'b1101;
            req_last[1]  = (b1 == 2);
            req_data[0]  = 8'h0A;
            req_data[1]  = 8'hB0 + 8'(b1);
            out_ready    = 1'b1;
            #1;
            if (in_gap) check("gap_req_ready0", 32'(req_ready[0]), 32'(gap_r0_exp));
            b1_acc = req_ready[1];
            cycle();
            if (b1_acc) b1++;
            if (out_valid) got_ids.push_back(int'(out_id));
        end
    endtask

    typedef struct {
        logic [N-1:0] valid;
        logic         ordy;
        logic [N-1:0] exp_rdy;
        logic         exp_ov;
        int           exp_id;
    } vec_t;

    vec_t  tbl[$];
    data_t tdata [N];
    int    exp_a [5];
    bit    gap_exp;

    initial begin
        tdata = '{8'h10, 8'h11, 8'h05, 8'h13};
`ifdef STREAM_ARB_LOCK_EN
        exp_a   = '{1, 1, 1, 0, 0};
        gap_exp = 1'b0;
`else
        exp_a   = '{1, 0, 1, 0, 1};
        gap_exp = 1'b1;
`endif
        // all valid: strict rotation, no bubbles
        tbl.push_back('{4'b1111, 1'b1, 4'b0001, 1'b1, 0});
        tbl.push_back('{4'b1111, 1'b1, 4'b0010, 1'b1, 1});
        tbl.push_back('{4'b1111, 1'b1, 4'b0100, 1'b1, 2});
        tbl.push_back('{4'b1111, 1'b1, 4'b1000, 1'b1, 3});
        tbl.push_back('{4'b1111, 1'b1, 4'b0001, 1'b1, 0});
        tbl.push_back('{4'b1111, 1'b1, 4'b0010, 1'b1, 1});
        // back-pressure: beat from req 1 held, nobody ready
        for (int i = 0; i < 5; i++) tbl.push_back('{4'b0011, 1'b0, 4'b0000, 1'b1, 1});
        tbl.push_back('{4'b0011, 1'b1, 4'b0001, 1'b1, 0});
        tbl.push_back('{4'b0011, 1'b1, 4'b0010, 1'b1, 1});
        // lone requester 2 gets every cycle
        for (int i = 0; i < 3; i++) tbl.push_back('{4'b0100, 1'b1, 4'b0100, 1'b1, 2});
        tbl.push_back('{4'b0000, 1'b1, 4'b0000, 1'b0, 0});

        do_reset();
        req_data = tdata;
        req_last = 4'b1111;
        for (int i = 0; i < tbl.size(); i++) begin
            req_valid = tbl[i].valid;
            out_ready = tbl[i].ordy;
            #1;
            check("tbl_req_ready", 32'(req_ready), 32'(tbl[i].exp_rdy));
            cycle();
            check("tbl_out_valid", 32'(out_valid), 32'(tbl[i].exp_ov));
            if (tbl[i].exp_ov) begin
                check("tbl_out_id", 32'(out_id), 32'(tbl[i].exp_id));
                check("tbl_out_data", 32'(out_data), 32'(tdata[tbl[i].exp_id]));
            end
        end

        // packet of 3 from req 1 competing with req 0
        do_reset();
        prep_ptr1();
        pkt_seq(5, 0, gap_exp);
        check("pkt_id_count", 32'(got_ids.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < got_ids.size()) check("pkt_id_seq", 32'(got_ids[i]), 32'(exp_a[i]));
        end

        // same packet with a 2-cycle valid gap after its first beat
        do_reset();
        prep_ptr1();
        pkt_seq(8, 2, gap_exp);

        // reset while a packet from req 2 is open and the slice is full
        do_reset();
        req_valid = 4'b0100;
        req_last  = 4'b0000;
        req_data  = tdata;
        cycle();
        req_valid = 4'b1111;
        req_last  = 4'b1111;
        rstn = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rstn = 1'b1;
        #1;
        check("midrst_grant", 32'(req_ready), 32'd1);
        cycle();
        check("midrst_out_id", 32'(out_id), 32'd0);

        // random traffic against the model
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            req_valid = 4'($urandom_range(0, 15));
            req_last  = 4'($urandom_range(0, 15));
            for (int i = 0; i < N; i++) req_data[i] = 8'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
